mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers. Sits in the E stage and consumes
//  the forwarded register-file operands (rs/rt). Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and
//  serves MFHI/MFLO reads. Exports busy/start so the hazard unit can stall MD-class instrs.
// PARAMETERS
//  MULT_CYCLES  5   busy duration (cycles) for MULT/MULTU, >=1
//  DIV_CYCLES   10  busy duration (cycles) for DIV/DIVU, >=1
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  reset     in   1   synchronous, active-high
//  start     in   1   issue md_op this cycle (E-stage instr is MD-class)
//  md_op     in   4   operation code (see constants), valid with start
//  req       in   1   exception/interrupt flush: suppress this cycle's issue
//  src_a     in   32  rs operand (forwarded GRF data)
//  src_b     in   32  rt operand (forwarded GRF data)
//  hi_sel    in   1   read select: 1=HI, 0=LO (MFHI/MFLO)
//  busy      out  1   multi-cycle op in flight
//  rd_data   out  32  HI or LO per hi_sel, combinational
// BEHAVIOUR
//  Reset: HI=0, LO=0, counter=0, busy=0; any in-flight op is discarded.
//  Issue accepted at posedge iff start & !req & !busy & !reset.
//  MULT/MULTU: operands captured at issue; {HI,LO} <= 64-bit signed/unsigned product,
//    written at the edge ending the MULT_CYCLES-th busy cycle.
//  DIV/DIVU: LO <= quotient, HI <= remainder, same timing with DIV_CYCLES.
//    Signed: quotient truncates toward zero, remainder takes dividend sign.
//    0x80000000 / -1 (signed): LO=0x80000000, HI=0.
//    Divisor 0: HI/LO unchanged at completion; busy still runs full DIV_CYCLES.
//  MTHI/MTLO: HI/LO <= src_a at the issue edge; no busy cycles.
//  MFHI/MFLO: no state change; rd_data = hi_sel ? HI : LO, reflects committed values only.
//  busy: rises the cycle after issue, stays high exactly N cycles, falls in the cycle
//    HI/LO show the result. Hazard unit stalls MD-class instrs on (start | busy); dependent MFHI/MFLO
//    see new result on the first non-busy cycle.
//  start while busy: ignored (hazard unit guarantees it does not occur; no state change).
//  req while busy: in-flight op completes normally (already committed); only a
//    simultaneous new issue is suppressed.
//  req with MTHI/MTLO: write suppressed, HI/LO unchanged.
//  Reset mid-operation: op aborted, HI/LO forced to 0, busy=0 next cycle.
//  Unknown md_op with start: treated as no-op, busy stays 0.
// STRUCTURE
//  Shared header: md_op encodings MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4,
//    MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8, MD_NONE=0; also used by decoder/hazard.
//  One sub-module: md_seq_ctrl (issue qualification, down-counter, busy, commit pulse).
//  Datapath (operand latches, result compute, HI/LO regs) stays in mult_div_unit.
// TESTING
//  reset; MTHI 0x12345678, MTLO 0x9ABCDEF0 -> next cycle HI/LO read back, busy never 1.
//  MULT 0xFFFFFFFF*0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE;
//    MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
//  DIV -7/2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged.
//  DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  MULT issued with req=1 -> busy stays 0, HI/LO unchanged; req at busy cycle 3 of a
//    DIV -> result still committed at cycle 10.
//  reset asserted at busy cycle 4 of MULT -> busy=0, HI=LO=0 next cycle; later MFLO reads 0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: md_op encodings (also used by the decoder and
// hazard unit) plus small op-class helpers.
package mult_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_seq_ctrl.sv
// Sequencing control for the multiply/divide unit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, req      issue request and flush (flush suppresses this cycle's issue)
//   multi           the requested op is multi-cycle (MULT/DIV class)
//   load            busy length for the requested op
//   accept          issue accepted at the coming posedge (combinational)
//   busy            multi-cycle op in flight (registered)
//   commit          this is the final busy cycle; result written at the coming edge
module md_seq_ctrl #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            req,
  input  logic            multi,
  input  logic [CntW-1:0] load,
  output logic            accept,
  output logic            busy,
  output logic            commit
);

  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  assign accept = start & ~req & ~busy_q & ~reset;
  assign commit = busy_q & (cnt_q == CntW'(1));
  assign busy   = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (accept && multi) begin
      cnt_q  <= load;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CntW'(1);
      // Drop busy on the same edge that writes HI/LO.
      if (cnt_q == CntW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (E stage).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, md_op    issue md_op this cycle
//   req             exception/interrupt flush: suppresses this cycle's issue
//   src_a, src_b    forwarded rs/rt operands
//   hi_sel          read select: 1=HI, 0=LO
//   busy            multi-cycle op in flight
//   rd_data         committed HI or LO (combinational)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic        req,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_sel,
  output logic        busy,
  output logic [31:0] rd_data
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic            accept, commit, multi;
  logic [CntW-1:0] load;
  logic [3:0]      op_q;
  logic [31:0]     a_q, b_q, hi_q, lo_q;

  assign multi = md_is_mult(md_op) | md_is_div(md_op);
  assign load  = md_is_mult(md_op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);

  md_seq_ctrl #(
    .CntW(CntW)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .req   (req),
    .multi (multi),
    .load  (load),
    .accept(accept),
    .busy  (busy),
    .commit(commit)
  );

  // Result compute from latched operands.
  logic        sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quot, rem;

  always_comb begin
    sgn   = md_is_signed(op_q);
    a_ext = {{32{sgn & a_q[31]}}, a_q};
    b_ext = {{32{sgn & b_q[31]}}, b_q};
    // Low 64 bits of the extended product give the signed or unsigned result.
    prod  = a_ext * b_ext;
    neg_a = sgn & a_q[31];
    neg_b = sgn & b_q[31];
    mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    // Divide-by-zero result is discarded; keep the divider well defined.
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq    = mag_a / div_b;
    ur    = mag_a % div_b;
    // Magnitude form also yields 0x80000000 / -1 = 0x80000000, rem 0.
    quot  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem   = neg_a ? (~ur + 32'd1) : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        if (multi) begin
          op_q <= md_op;
          a_q  <= src_a;
          b_q  <= src_b;
        end
        if (md_op == MD_MTHI) hi_q <= src_a;
        if (md_op == MD_MTLO) lo_q <= src_a;
      end
      if (commit) begin
        if (md_is_mult(op_q)) begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end else if (md_is_div(op_q) && (b_q != 32'd0)) begin
          hi_q <= rem;
          lo_q <= quot;
        end
      end
    end
  end

  assign rd_data = hi_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, req, hi_sel, busy;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b, rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .req    (req),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_sel (hi_sel),
    .busy   (busy),
    .rd_data(rd_data)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hl(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h, l;
    hi_sel = 1'b1;
    #1 h = rd_data;
    hi_sel = 1'b0;
    #1 l = rd_data;
    check({tag, "_hi"}, h, ehi);
    check({tag, "_lo"}, l, elo);
  endtask

  // Issue one op, then count busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; req = 1'b0; hi_sel = 1'b0;
    md_op = MD_NONE; src_a = '0; src_b = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check_hl("reset", 32'h0, 32'h0);

    // MTHI / MTLO
    start = 1'b1; md_op = MD_MTHI; src_a = 32'h12345678;
    step();
    check("mthi_busy", 32'(busy), 32'd0);
    md_op = MD_MTLO; src_a = 32'h9ABCDEF0;
    step();
    start = 1'b0;
    check("mtlo_busy", 32'(busy), 32'd0);
    check_hl("mt", 32'h12345678, 32'h9ABCDEF0);

    // MULT: check committed values stay visible during busy
    md_op = MD_MULT; src_a = 32'hFFFFFFFF; src_b = 32'h2; start = 1'b1;
    step();
    start = 1'b0;
    check("mult_busy_rise", 32'(busy), 32'd1);
    check_hl("mult_inflight", 32'h12345678, 32'h9ABCDEF0);
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      step();
      if (busy === 1'b1) n++;
    end
    check("mult_cycles", 32'(n), 32'd5);
    check_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h2, n);
    check("multu_cycles", 32'(n), 32'd5);
    check_hl("multu", 32'h00000001, 32'hFFFFFFFE);

    run_op(MD_DIV, 32'hFFFFFFF9, 32'h2, n);
    check("div_cycles", 32'(n), 32'd10);
    check_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run_op(MD_DIVU, 32'h7, 32'h0, n);
    check("divu0_cycles", 32'(n), 32'd10);
    check_hl("divu0", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    check("divovf_cycles", 32'(n), 32'd10);
    check_hl("divovf", 32'h00000000, 32'h80000000);

    // MULT with req: suppressed
    md_op = MD_MULT; src_a = 32'h3; src_b = 32'h4; start = 1'b1; req = 1'b1;
    step();
    start = 1'b0; req = 1'b0;
    check("req_mult_busy", 32'(busy), 32'd0);
    step(); step(); step(); step(); step(); step();
    check_hl("req_mult", 32'h00000000, 32'h80000000);

    // MTLO with req: suppressed
    md_op = MD_MTLO; src_a = 32'hDEADBEEF; start = 1'b1; req = 1'b1;
    step();
    start = 1'b0; req = 1'b0;
    check_hl("req_mtlo", 32'h00000000, 32'h80000000);

    // Unknown op: no-op
    md_op = 4'd9; src_a = 32'h55; start = 1'b1;
    step();
    start = 1'b0;
    check("unk_busy", 32'(busy), 32'd0);
    check_hl("unk", 32'h00000000, 32'h80000000);

    // DIV 100/7 with req (and a stray start) in busy cycle 3
    md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      req   = (n == 3);
      start = (n == 3);
      md_op = MD_MTHI;
      src_a = 32'hBAD0BAD0;
      step();
    end
    req = 1'b0; start = 1'b0;
    check("reqdiv_cycles", 32'(n), 32'd10);
    check_hl("reqdiv", 32'd2, 32'd14);

    // Reset at busy cycle 4 of MULT
    md_op = MD_MULT; src_a = 32'h3; src_b = 32'h4; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check_hl("rst_mid", 32'h0, 32'h0);
    step(); step(); step(); step(); step(); step();
    md_op = MD_MFLO; start = 1'b1; hi_sel = 1'b0;
    step();
    start = 1'b0;
    check("mflo_busy", 32'(busy), 32'd0);
    #1 check("mflo_read", rd_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
